// File: rtl/bcd_accumulator.sv
// bcd_accumulator
//   Binary accumulator driven by a 4-bit operation request (+1, +2, x2, x3).
//   Each accepted request updates the accumulator. A sequential double-dabble
//   converter then produces the BCD result, one bit per cycle. A lockout FSM
//   (IDLE -> LOCK -> RELEASE) makes sure a held request yields only one
//   operation.
//
//   Parameters
//     DIGITS     number of BCD output digits (1..8), MAX = 10^DIGITS-1
//     LOCKOUT    request lockout length in cycles (> 4*DIGITS+4)
//     INIT_VALUE accumulator value after reset (0..MAX)
//
//   Ports
//     Clk       in   rising-edge clock
//     Reset     in   asynchronous, active-low reset
//     Trigger   in   [3:0] bit0 +1, bit1 +2, bit2 x2, bit3 x3
//     Digits    out  [4*DIGITS-1:0] BCD result, digit 0 in the low nibble
//     Busy      out  conversion in progress
//     Done      out  one-cycle pulse when Digits takes a new value
//     Overflow  out  sticky, set when a result exceeds MAX
//
//   Configuration macro BCD_ACCUMULATOR_SAT_EN
//     defined   : an overflowing result saturates the accumulator to MAX
//     undefined : an overflowing result is stored and freezes the
//                 accumulator. Digits then shows all 4'hF until reset.
module bcd_accumulator #(
  parameter int DIGITS     = 4,
  parameter int LOCKOUT    = 1024,
  parameter int INIT_VALUE = 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [3:0]            Trigger,
  output logic [4*DIGITS-1:0]   Digits,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Overflow
);

  localparam int AW  = 4*DIGITS+2;      // wide enough for 3*MAX
  localparam int BW  = 4*DIGITS;
  localparam int CW  = $clog2(LOCKOUT);
  localparam int SCW = $clog2(AW+1);

  function automatic longint pow10m1(input int n);
    longint m;
    m = 1;
    for (int i = 0; i < n; i++) m = m * 10;
    return m - 1;
  endfunction

  function automatic logic [BW-1:0] to_bcd(input longint v);
    logic [BW-1:0] r;
    longint        t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // One double-dabble step on {bcd, binary}: add 3 to every digit >= 5,
  // then shift the whole register left by one bit.
  function automatic logic [BW+AW-1:0] dabble_step(input logic [BW+AW-1:0] v);
    logic [BW+AW-1:0] r;
    r = v;
    for (int k = 0; k < DIGITS; k++) begin
      if (r[AW+4*k +: 4] >= 4'd5) r[AW+4*k +: 4] = r[AW+4*k +: 4] + 4'd3;
    end
    return r << 1;
  endfunction

  localparam logic [AW-1:0] MAX      = AW'(pow10m1(DIGITS));
  localparam logic [BW-1:0] INIT_BCD = to_bcd(longint'(INIT_VALUE));

  typedef enum logic [1:0] {S_IDLE, S_LOCK, S_RELEASE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             accept;
  logic             op_en;
  logic             frozen;

  logic [AW-1:0]    acc_q;
  logic [AW-1:0]    sum;
  logic [AW-1:0]    acc_new;
  logic             over;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;
  logic [BW-1:0]    digits_q;
  logic [SCW-1:0]   scnt_q;
  logic [BW+AW-1:0] dd_q;
`ifndef BCD_ACCUMULATOR_SAT_EN
  logic             fpend_q;
`endif

  // ---- lockout FSM: state register ----
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---- lockout FSM: next state ----
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (Trigger != 4'd0) begin
          state_d = S_LOCK;
          cnt_d   = CW'(1);
        end
      end
      S_LOCK: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_d == CW'(LOCKOUT-1)) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (Trigger == 4'd0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---- lockout FSM: outputs ----
  // Only a one-hot request changes the accumulator. Any nonzero request
  // still starts the lockout.
  always_comb begin
    accept = (state_q == S_IDLE) && (Trigger != 4'd0);
    op_en  = accept && $onehot(Trigger) && !frozen;
  end

`ifdef BCD_ACCUMULATOR_SAT_EN
  assign frozen = 1'b0;
`else
  assign frozen = ovf_q;
`endif

  // ---- operation arithmetic ----
  always_comb begin
    case (Trigger)
      4'b0001: sum = acc_q + AW'(1);
      4'b0010: sum = acc_q + AW'(2);
      4'b0100: sum = acc_q << 1;
      4'b1000: sum = acc_q + (acc_q << 1);
      default: sum = acc_q;
    endcase
    over = (sum > MAX);
`ifdef BCD_ACCUMULATOR_SAT_EN
    acc_new = over ? MAX : sum;
`else
    acc_new = sum;
`endif
  end

  // ---- accumulator, converter control, result ----
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      acc_q    <= AW'(INIT_VALUE);
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      digits_q <= INIT_BCD;
      scnt_q   <= '0;
`ifndef BCD_ACCUMULATOR_SAT_EN
      fpend_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (op_en) begin
        acc_q <= acc_new;
        if (over) ovf_q <= 1'b1;
`ifdef BCD_ACCUMULATOR_SAT_EN
        busy_q <= 1'b1;
        scnt_q <= '0;
`else
        // Overflow skips the conversion. The all-F result is shown next cycle.
        if (over) begin
          fpend_q <= 1'b1;
        end else begin
          busy_q <= 1'b1;
          scnt_q <= '0;
        end
`endif
      end else if (busy_q) begin
        // After AW shift steps the BCD half is complete. Publish it in one go.
        if (scnt_q == SCW'(AW)) begin
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          digits_q <= dd_q[AW +: BW];
        end else begin
          scnt_q <= scnt_q + SCW'(1);
        end
      end
`ifndef BCD_ACCUMULATOR_SAT_EN
      if (fpend_q) begin
        fpend_q  <= 1'b0;
        done_q   <= 1'b1;
        digits_q <= '1;
      end
`endif
    end
  end

  // ---- double-dabble shift register (scratch, only meaningful while busy) ----
  always_ff @(posedge Clk) begin
    if (op_en) begin
      dd_q <= {{BW{1'b0}}, acc_new};
    end else if (busy_q && (scnt_q != SCW'(AW))) begin
      dd_q <= dabble_step(dd_q);
    end
  end

  assign Digits   = digits_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_bcd_accumulator.sv
module tb_bcd_accumulator;

  localparam int D    = 4;
  localparam int LOCK = 1024;
  localparam int INIT = 1;

  logic           Clk = 1'b0;
  logic           Reset = 1'b0;
  logic [3:0]     Trigger = 4'd0;
  logic [4*D-1:0] Digits;
  logic           Busy;
  logic           Done;
  logic           Overflow;

  bcd_accumulator #(
    .DIGITS     (D),
    .LOCKOUT    (LOCK),
    .INIT_VALUE (INIT)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Trigger  (Trigger),
    .Digits   (Digits),
    .Busy     (Busy),
    .Done     (Done),
    .Overflow (Overflow)
  );

  always #5 Clk = ~Clk;

  int passes   = 0;
  int total    = 0;
  int done_cnt = 0;

  // Pulses are counted on the rising edge, which samples the previous cycle's Done.
  always @(posedge Clk) if (Done === 1'b1) done_cnt++;

  // Reference model: plain integer arithmetic on the accumulator value.
  longint         macc;
  bit             mfrozen;
  bit             movf;
  logic [4*D-1:0] mdig;
  longint         maxv;

  function automatic logic [4*D-1:0] bcd(input longint v);
    logic [4*D-1:0] r;
    longint         t;
    r = '0;
    t = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    macc    = INIT;
    mfrozen = 1'b0;
    movf    = 1'b0;
    mdig    = bcd(INIT);
  endtask

  task automatic model_op(input logic [3:0] t, output bit exp_done);
    longint nv;
    exp_done = 1'b0;
    if ($countones(t) == 1 && !mfrozen) begin
      if (t[0])      nv = macc + 1;
      else if (t[1]) nv = macc + 2;
      else if (t[2]) nv = macc * 2;
      else           nv = macc * 3;
      exp_done = 1'b1;
      if (nv > maxv) begin
        movf = 1'b1;
`ifdef BCD_ACCUMULATOR_SAT_EN
        macc = maxv;
        mdig = bcd(maxv);
`else
        macc    = nv;
        mfrozen = 1'b1;
        mdig    = '1;
`endif
      end else begin
        macc = nv;
        mdig = bcd(nv);
      end
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called at a falling edge: drives one request, holds it, and waits out
  // the lockout before checking the result.
  task automatic do_op(input string tag, input logic [3:0] t, input int hold);
    bit ed;
    int d0;
    int n;
    model_op(t, ed);
    d0 = done_cnt;
    Trigger = t;
    repeat (hold) @(negedge Clk);
    Trigger = 4'd0;
    n = (hold < LOCK + 4) ? (LOCK + 8 - hold) : 4;
    repeat (n) @(negedge Clk);
    check({tag, " done"}, 64'(done_cnt - d0), 64'(ed));
    check({tag, " digits"}, 64'(Digits), 64'(mdig));
    check({tag, " ovf"}, 64'(Overflow), 64'(movf));
  endtask

  // Called at a falling edge: asserts reset, checks outputs without a clock edge.
  task automatic reset_pulse(input string tag, input int hold);
    Reset = 1'b0;
    #1;
    model_reset();
    check({tag, " rst digits"}, 64'(Digits), 64'(bcd(INIT)));
    check({tag, " rst busy"}, 64'(Busy), 64'd0);
    check({tag, " rst done"}, 64'(Done), 64'd0);
    check({tag, " rst ovf"}, 64'(Overflow), 64'd0);
    repeat (hold) @(negedge Clk);
    Reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] seq [15];
    bit         ed;
    int         d0;
    int         k;
    logic       b1;
    logic       busy_at_done;
    logic [3:0] t;
    int         r;

    maxv = 1;
    for (int i = 0; i < D; i++) maxv = maxv * 10;
    maxv = maxv - 1;
    model_reset();

    // Reset state
    @(negedge Clk);
    reset_pulse("init", 3);

    // Single +1 held three cycles: one conversion with fixed latency
    model_op(4'b0001, ed);
    d0 = done_cnt;
    Trigger = 4'b0001;
    k = 0;
    b1 = 1'b0;
    busy_at_done = 1'b1;
    for (int i = 1; i <= 60 && k == 0; i++) begin
      @(negedge Clk);
      if (i == 1) b1 = Busy;
      if (i == 3) Trigger = 4'd0;
      if (Done === 1'b1) begin
        k = i;
        busy_at_done = Busy;
      end
    end
    check("latency", 64'(k), 64'(4*D+4));
    check("busy rise", 64'(b1), 64'd1);
    check("busy at done", 64'(busy_at_done), 64'd0);
    check("first digits", 64'(Digits), 64'(mdig));
    repeat (LOCK + 8 - k) @(negedge Clk);
    check("single done", 64'(done_cnt - d0), 64'd1);
    check("digits stable", 64'(Digits), 64'h0002);

    // Long-held x2 then one x3 pulse
    do_op("held x2", 4'b0100, 3000);
    do_op("pulse x3", 4'b1000, 1);

    // Non-one-hot request: lockout only
    @(negedge Clk);
    reset_pulse("pre non1hot", 2);
    do_op("non1hot", 4'b0011, 2);
    check("non1hot digits", 64'(Digits), 64'h0001);

    // Randomized requests against the model
    for (int i = 0; i < 10; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 8) t = 4'b0001 << (r % 4);
      else if (r == 8) t = 4'b0110;
      else t = 4'b1100;
      do_op($sformatf("rand%0d", i), t, int'($urandom_range(1, 6)));
    end

    // Build 3333, then x3 to MAX, then overflow
    @(negedge Clk);
    reset_pulse("pre build", 2);
    seq = '{4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0001,
            4'b0100, 4'b0100, 4'b0100, 4'b0001, 4'b0100, 4'b1000, 4'b0001,
            4'b1000};
    for (int i = 0; i < 15; i++) do_op($sformatf("build%0d", i), seq[i], 1);
    check("at 3333", 64'(Digits), 64'h3333);
    do_op("to max", 4'b1000, 1);
    check("max digits", 64'(Digits), 64'h9999);
    check("max no ovf", 64'(Overflow), 64'd0);
    do_op("overflow", 4'b0001, 1);
`ifdef BCD_ACCUMULATOR_SAT_EN
    check("ovf digits", 64'(Digits), 64'h9999);
`else
    check("ovf digits", 64'(Digits), 64'hFFFF);
`endif
    do_op("after ovf", 4'b0001, 1);

    // Reset in the middle of a conversion
    @(negedge Clk);
    reset_pulse("pre midconv", 2);
    model_op(4'b0100, ed);
    Trigger = 4'b0100;
    repeat (5) @(negedge Clk);
    Trigger = 4'd0;
    check("midconv busy", 64'(Busy), 64'd1);
    d0 = done_cnt;
    reset_pulse("midconv", 30);
    check("midconv no done", 64'(done_cnt - d0), 64'd0);
    do_op("after midconv", 4'b0010, 1);

    // Reset in the middle of the lockout
    model_op(4'b0100, ed);
    Trigger = 4'b0100;
    repeat (2) @(negedge Clk);
    Trigger = 4'd0;
    repeat (100) @(negedge Clk);
    d0 = done_cnt;
    reset_pulse("midlock", 3);
    check("midlock no done", 64'(done_cnt - d0), 64'd0);
    do_op("after midlock", 4'b0001, 1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
